// File: rtl/viterbi_pkg.sv
// Shared constants and trellis connectivity helpers for the Viterbi datapath.
package viterbi_pkg;

  localparam int unsigned DEF_NUM_STATES = 8;
  localparam int unsigned DEF_BM_W       = 2;
  localparam int unsigned DEF_PM_W       = 6;
  localparam int unsigned DEF_INIT_PM    = 16;
  localparam int unsigned DEF_ST_W       = $clog2(DEF_NUM_STATES);

  // Predecessor feeding state s through the decision-0 branch.
  function automatic int unsigned pred0(input int unsigned s, input int unsigned n);
    return (2 * s) % n;
  endfunction

  // Predecessor feeding state s through the decision-1 branch.
  function automatic int unsigned pred1(input int unsigned s, input int unsigned n);
    return (2 * s + 1) % n;
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One trellis state: two saturating adds, borrow-based compare and select.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int unsigned BM_W = DEF_BM_W,
  parameter int unsigned PM_W = DEF_PM_W
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W-1:0] pm_c,
  output logic            dec_c,
  output logic            msb_c
);

  localparam int unsigned SUM_W = PM_W + 1;
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [SUM_W-1:0] sum0;
  logic [SUM_W-1:0] sum1;
  logic [SUM_W-1:0] diff;
  logic [PM_W-1:0]  c0;
  logic [PM_W-1:0]  c1;

  // Carry out of the extra sum bit means overflow; clamp to the top code.
  always_comb begin
    sum0  = SUM_W'(pm0_i) + SUM_W'(bm0_i);
    sum1  = SUM_W'(pm1_i) + SUM_W'(bm1_i);
    c0    = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
    c1    = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
    diff  = SUM_W'(c1) - SUM_W'(c0);
    dec_c = diff[PM_W];
    pm_c  = dec_c ? c1 : c0;
    msb_c = pm_c[PM_W-1];
  end

endmodule

// File: rtl/pm_acs_array.sv
// ACS array with registered path metrics, automatic normalisation and
// best-state tracking; sits between branch-metric unit and traceback.
module pm_acs_array
  import viterbi_pkg::*;
#(
  parameter int unsigned NUM_STATES = DEF_NUM_STATES,
  parameter int unsigned BM_W       = DEF_BM_W,
  parameter int unsigned PM_W       = DEF_PM_W,
  parameter int unsigned INIT_PM    = DEF_INIT_PM,
  localparam int unsigned ST_W      = $clog2(NUM_STATES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       bm_valid,
  input  logic [NUM_STATES*BM_W-1:0] bm0_in,
  input  logic [NUM_STATES*BM_W-1:0] bm1_in,
  output logic                       dec_valid,
  output logic [NUM_STATES-1:0]      dec_out,
  output logic [ST_W-1:0]            best_state,
  output logic                       norm_evt,
  output logic [NUM_STATES*PM_W-1:0] pm_out
);

  if ((NUM_STATES < 2) || ((NUM_STATES & (NUM_STATES - 1)) != 0)) begin : g_bad_states
    $error("pm_acs_array: NUM_STATES must be a power of two >= 2");
  end
  if (PM_W < BM_W + 3) begin : g_bad_pm_w
    $error("pm_acs_array: PM_W must be at least BM_W+3");
  end

  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

  logic [PM_W-1:0]       pm_q   [NUM_STATES];
  logic [PM_W-1:0]       pm_d   [NUM_STATES];
  logic [PM_W-1:0]       sel_pm [NUM_STATES];
  logic [NUM_STATES-1:0] sel_dec;
  logic [NUM_STATES-1:0] sel_msb;
  logic [NUM_STATES-1:0] dec_q;
  logic [NUM_STATES-1:0] dec_d;
  logic [ST_W-1:0]       best_q;
  logic [ST_W-1:0]       best_d;
  logic [ST_W-1:0]       min_idx;
  logic [PM_W-1:0]       min_pm;
  logic                  dec_valid_q;
  logic                  dec_valid_d;
  logic                  norm_q;
  logic                  norm_d;
  logic                  norm_hit;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam int unsigned P0 = pred0(s, NUM_STATES);
    localparam int unsigned P1 = pred1(s, NUM_STATES);

    acs_cell #(
      .BM_W (BM_W),
      .PM_W (PM_W)
    ) u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm0_in[s*BM_W +: BM_W]),
      .bm1_i (bm1_in[s*BM_W +: BM_W]),
      .pm_c  (sel_pm[s]),
      .dec_c (sel_dec[s]),
      .msb_c (sel_msb[s])
    );

    assign pm_out[s*PM_W +: PM_W] = pm_q[s];
  end

  // All survivors in the upper half: subtracting half-range is lossless.
  assign norm_hit = &sel_msb;

  // Argmin over pre-normalisation metrics; strict compare keeps the lowest index on ties.
  always_comb begin
    min_pm  = sel_pm[0];
    min_idx = '0;
    for (int unsigned i = 1; i < NUM_STATES; i++) begin
      if (sel_pm[i] < min_pm) begin
        min_pm  = sel_pm[i];
        min_idx = ST_W'(i);
      end
    end
  end

  // Next-state selection: start overrides a valid step, idle holds everything.
  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    best_d      = best_q;
    dec_valid_d = 1'b0;
    norm_d      = 1'b0;
    if (start) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pm_d[i] = (i == 0) ? '0 : PM_INIT;
      end
      dec_d  = '0;
      best_d = '0;
    end else if (bm_valid) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pm_d[i] = norm_hit ? {1'b0, sel_pm[i][PM_W-2:0]} : sel_pm[i];
      end
      dec_d       = sel_dec;
      best_d      = min_idx;
      dec_valid_d = 1'b1;
      norm_d      = norm_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        pm_q[i] <= (i == 0) ? '0 : PM_INIT;
      end
      dec_q       <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
      norm_q      <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      best_q      <= best_d;
      dec_valid_q <= dec_valid_d;
      norm_q      <= norm_d;
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_out    = dec_q;
  assign best_state = best_q;
  assign norm_evt   = norm_q;

endmodule

// File: tb/tb_pm_acs_array.sv
// Scoreboard bench for pm_acs_array: directed steps with hand-derived metrics.
module tb_pm_acs_array;

  typedef struct packed {
    logic [47:0] pm;
    logic [7:0]  dec;
    logic [2:0]  best;
    logic        norm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bm_valid;
  logic        start2;
  logic        bm_valid2;
  logic [15:0] bm0;
  logic [15:0] bm1;

  logic        dv;
  logic [7:0]  dec;
  logic [2:0]  best;
  logic        norm;
  logic [47:0] pm;
  logic        dv2;
  logic [7:0]  dec2;
  logic [2:0]  best2;
  logic        norm2;
  logic [47:0] pm2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pm_acs_array u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bm_valid   (bm_valid),
    .bm0_in     (bm0),
    .bm1_in     (bm1),
    .dec_valid  (dv),
    .dec_out    (dec),
    .best_state (best),
    .norm_evt   (norm),
    .pm_out     (pm)
  );

  // Second instance starts high so overflow of the adders is reachable.
  pm_acs_array #(
    .NUM_STATES (8),
    .BM_W       (2),
    .PM_W       (6),
    .INIT_PM    (62)
  ) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .bm_valid   (bm_valid2),
    .bm0_in     (bm0),
    .bm1_in     (bm1),
    .dec_valid  (dv2),
    .dec_out    (dec2),
    .best_state (best2),
    .norm_evt   (norm2),
    .pm_out     (pm2)
  );

  function automatic logic [47:0] pk(input int v0, input int v1, input int v2, input int v3,
                                     input int v4, input int v5, input int v6, input int v7);
    return {6'(v7), 6'(v6), 6'(v5), 6'(v4), 6'(v3), 6'(v2), 6'(v1), 6'(v0)};
  endfunction

  function automatic exp_t mk(input logic [47:0] p, input logic [7:0] d,
                              input logic [2:0] b, input logic n);
    exp_t e;
    e.pm   = p;
    e.dec  = d;
    e.best = b;
    e.norm = n;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per dec_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (dv === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut unexpected dec_valid", 64'(dv), 64'd0);
      end else begin
        e = q1.pop_front();
        chk("dut pm_out", 64'(pm), 64'(e.pm));
        chk("dut dec_out", 64'(dec), 64'(e.dec));
        chk("dut best_state", 64'(best), 64'(e.best));
        chk("dut norm_evt", 64'(norm), 64'(e.norm));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dv2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("sat unexpected dec_valid", 64'(dv2), 64'd0);
      end else begin
        e = q2.pop_front();
        chk("sat pm_out", 64'(pm2), 64'(e.pm));
        chk("sat dec_out", 64'(dec2), 64'(e.dec));
        chk("sat best_state", 64'(best2), 64'(e.best));
        chk("sat norm_evt", 64'(norm2), 64'(e.norm));
      end
    end
  end

  task automatic step(input logic [15:0] b0, input logic [15:0] b1, input exp_t e);
    @(negedge clk);
    bm0       = b0;
    bm1       = b1;
    start     = 1'b0;
    bm_valid  = 1'b1;
    bm_valid2 = 1'b0;
    q1.push_back(e);
  endtask

  task automatic step_sat(input logic [15:0] b0, input logic [15:0] b1, input exp_t e);
    @(negedge clk);
    bm0       = b0;
    bm1       = b1;
    bm_valid  = 1'b0;
    bm_valid2 = 1'b1;
    q2.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bm_valid  = 1'b0;
    bm_valid2 = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
  endtask

  // start together with bm_valid and non-zero metrics; start must win.
  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    bm_valid = 1'b1;
    bm0      = 16'hFFFF;
    bm1      = 16'hFFFF;
    @(negedge clk);
    start    = 1'b0;
    bm_valid = 1'b0;
    chk("start dec_valid", 64'(dv), 64'd0);
    chk("start pm_out", 64'(pm), 64'(pk(0, 16, 16, 16, 16, 16, 16, 16)));
    chk("start dec_out", 64'(dec), 64'd0);
    chk("start best_state", 64'(best), 64'd0);
    chk("start norm_evt", 64'(norm), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] p;
    exp_t        e_zero;
    exp_t        e_aa;
    rst       = 1'b1;
    start     = 1'b0;
    bm_valid  = 1'b0;
    start2    = 1'b0;
    bm_valid2 = 1'b0;
    bm0       = '0;
    bm1       = '0;
    e_zero    = mk(pk(0, 16, 16, 16, 0, 16, 16, 16), 8'h00, 3'd0, 1'b0);
    e_aa      = mk(pk(3, 16, 3, 16, 3, 16, 3, 16), 8'hAA, 3'd0, 1'b0);

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset pm_out", 64'(pm), 64'(pk(0, 16, 16, 16, 16, 16, 16, 16)));
    chk("reset dec_valid", 64'(dv), 64'd0);
    chk("reset best_state", 64'(best), 64'd0);
    chk("reset norm_evt", 64'(norm), 64'd0);
    chk("reset dec_out", 64'(dec), 64'd0);
    chk("reset sat pm_out", 64'(pm2), 64'(pk(0, 62, 62, 62, 62, 62, 62, 62)));
    rst = 1'b0;

    // Zero branch metrics: ties resolve to p0, then idle holds
    step(16'h0000, 16'h0000, e_zero);
    idle();
    @(negedge clk);
    chk("pulse dec_valid low", 64'(dv), 64'd0);
    chk("hold pm_out", 64'(pm), 64'(e_zero.pm));
    chk("hold best_state", 64'(best), 64'd0);

    // Single costly branch into state 0 moves the minimum to state 4
    do_start();
    step(16'h0003, 16'h0000, mk(pk(3, 16, 16, 16, 0, 16, 16, 16), 8'h00, 3'd4, 1'b0));

    // Odd predecessors cheaper on the p1 branch
    do_start();
    step(16'h0000, 16'h0000, e_zero);
    step(16'hFFFF, 16'h0000, e_aa);

    // Continuous maximum metrics until normalisation fires
    do_start();
    for (int k = 1; k <= 11; k++) begin
      if (k == 1)       p = pk(3, 19, 19, 19, 3, 19, 19, 19);
      else if (k == 2)  p = pk(6, 22, 6, 22, 6, 22, 6, 22);
      else if (k < 11)  p = pk(3*k, 3*k, 3*k, 3*k, 3*k, 3*k, 3*k, 3*k);
      else              p = pk(1, 1, 1, 1, 1, 1, 1, 1);
      step(16'hFFFF, 16'hFFFF, mk(p, 8'h00, 3'd0, 1'(k == 11)));
    end

    // Normalisation with unequal metrics, then a step from the shifted metrics
    do_start();
    for (int k = 1; k <= 10; k++) begin
      if (k == 1)       p = pk(3, 19, 19, 19, 3, 19, 19, 19);
      else if (k == 2)  p = pk(6, 22, 6, 22, 6, 22, 6, 22);
      else              p = pk(3*k, 3*k, 3*k, 3*k, 3*k, 3*k, 3*k, 3*k);
      step(16'hFFFF, 16'hFFFF, mk(p, 8'h00, 3'd0, 1'b0));
    end
    step(16'hFEFB, 16'hFEFB, mk(pk(1, 0, 1, 1, 0, 1, 1, 1), 8'h00, 3'd1, 1'b1));
    step(16'hFFFF, 16'hFFFF, mk(pk(3, 4, 3, 4, 3, 4, 3, 4), 8'h11, 3'd0, 1'b0));
    idle();

    // Saturation near the top of the metric range
    step_sat(16'hFFFF, 16'hFFFF, mk(pk(3, 63, 63, 63, 3, 63, 63, 63), 8'h00, 3'd0, 1'b0));
    step_sat(16'hFFFF, 16'hFFFF, mk(pk(6, 63, 6, 63, 6, 63, 6, 63), 8'h00, 3'd0, 1'b0));
    step_sat(16'hFFFF, 16'hFFFF, mk(pk(9, 9, 9, 9, 9, 9, 9, 9), 8'h00, 3'd0, 1'b0));
    idle();

    // start mid-stream, then asynchronous reset between clock edges
    do_start();
    step(16'h0000, 16'h0000, e_zero);
    step(16'hFFFF, 16'h0000, e_aa);
    do_start();
    step(16'h0000, 16'h0000, e_zero);
    step(16'hFFFF, 16'h0000, e_aa);
    @(negedge clk);
    bm_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async rst dec_valid", 64'(dv), 64'd0);
    chk("async rst pm_out", 64'(pm), 64'(pk(0, 16, 16, 16, 16, 16, 16, 16)));
    chk("async rst dec_out", 64'(dec), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(16'h0000, 16'h0000, e_zero);
    idle();
    idle();

    chk("scoreboard drained", 64'(q1.size() + q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
